// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel/line counters with horizontal and vertical phase
// FSMs driving registered sync, blanking and wrap pulses, advanced by pix_tick.
module vga_sync_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       CLK_in,
    input  logic       reset,
    input  logic       pix_tick,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       line_end,
    output logic       frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST        = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_FRONT_START = 10'(H_VISIBLE);
    localparam logic [9:0] H_SYNC_START  = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] H_BACK_START  = 10'(H_VISIBLE + H_FRONT + H_SYNC);

    localparam logic [9:0] V_LAST        = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_FRONT_START = 10'(V_VISIBLE);
    localparam logic [9:0] V_SYNC_START  = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_BACK_START  = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    typedef enum logic [1:0] {
        H_ST_ACTIVE,
        H_ST_FRONT,
        H_ST_SYNC,
        H_ST_BACK
    } h_state_t;

    typedef enum logic [1:0] {
        V_ST_ACTIVE,
        V_ST_FRONT,
        V_ST_SYNC,
        V_ST_BACK
    } v_state_t;

    logic [9:0] r_pixel_x;
    logic [9:0] r_pixel_y;
    h_state_t   r_h_state;
    v_state_t   r_v_state;
    logic       r_hsync;
    logic       r_vsync;
    logic       r_video_on;
    logic       r_line_end;
    logic       r_frame_start;

    logic       w_x_last;
    logic       w_y_last;
    logic [9:0] w_x_next;
    logic [9:0] w_y_next;
    h_state_t   w_h_state_next;
    v_state_t   w_v_state_next;

    // Position the counters will hold after the next tick; all registered
    // outputs are decoded from it so they line up with the counters.
    assign w_x_last = (r_pixel_x == H_LAST);
    assign w_y_last = (r_pixel_y == V_LAST);
    assign w_x_next = w_x_last ? '0 : r_pixel_x + 10'd1;
    assign w_y_next = !w_x_last ? r_pixel_y :
                      (w_y_last ? '0 : r_pixel_y + 10'd1);

    always_comb begin
        // NOTE: default assignment first, so no path leaves it unassigned and no latch is inferred.
        w_h_state_next = r_h_state;
        case (r_h_state)
            H_ST_ACTIVE: if (w_x_next == H_FRONT_START) w_h_state_next = H_ST_FRONT;
            H_ST_FRONT:  if (w_x_next == H_SYNC_START)  w_h_state_next = H_ST_SYNC;
            H_ST_SYNC:   if (w_x_next == H_BACK_START)  w_h_state_next = H_ST_BACK;
            H_ST_BACK:   if (w_x_next == '0)            w_h_state_next = H_ST_ACTIVE;
            default:                                    w_h_state_next = H_ST_ACTIVE;
        endcase
    end

    // The vertical phase only moves on the tick that wraps the line.
    always_comb begin
        w_v_state_next = r_v_state;
        if (w_x_last) begin
            case (r_v_state)
                V_ST_ACTIVE: if (w_y_next == V_FRONT_START) w_v_state_next = V_ST_FRONT;
                V_ST_FRONT:  if (w_y_next == V_SYNC_START)  w_v_state_next = V_ST_SYNC;
                V_ST_SYNC:   if (w_y_next == V_BACK_START)  w_v_state_next = V_ST_BACK;
                V_ST_BACK:   if (w_y_next == '0)            w_v_state_next = V_ST_ACTIVE;
                default:                                    w_v_state_next = V_ST_ACTIVE;
            endcase
        end
    end

    always_ff @(posedge CLK_in or posedge reset) begin
        if (reset) begin
            r_pixel_x     <= '0;
            r_pixel_y     <= '0;
            r_h_state     <= H_ST_ACTIVE;
            r_v_state     <= V_ST_ACTIVE;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_video_on    <= 1'b0;
            r_line_end    <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
            // Pulses drop on every edge; only a wrapping tick raises them again.
            r_line_end    <= 1'b0;
            r_frame_start <= 1'b0;
            if (pix_tick) begin
                r_pixel_x     <= w_x_next;
                r_pixel_y     <= w_y_next;
                r_h_state     <= w_h_state_next;
                r_v_state     <= w_v_state_next;
                r_hsync       <= (w_h_state_next != H_ST_SYNC);
                r_vsync       <= (w_v_state_next != V_ST_SYNC);
                r_video_on    <= (w_h_state_next == H_ST_ACTIVE) &&
                                 (w_v_state_next == V_ST_ACTIVE);
                r_line_end    <= w_x_last;
                r_frame_start <= w_x_last && w_y_last;
            end
        end
    end

    assign pixel_x     = r_pixel_x;
    assign pixel_y     = r_pixel_y;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign video_on    = r_video_on;
    assign line_end    = r_line_end;
    assign frame_start = r_frame_start;

endmodule
